// File: rtl/axi4_lite_intl_regbank_if.sv
// AXI4-Lite channel bundle for the interlock register bank.
interface axi4_lite_intl_regbank_if #(
  parameter int unsigned AddrWidth = 8,
  parameter int unsigned DataWidth = 32
);
  logic [AddrWidth-1:0]   awaddr;
  logic [2:0]             awprot;
  logic                   awvalid;
  logic                   awready;
  logic [DataWidth-1:0]   wdata;
  logic [DataWidth/8-1:0] wstrb;
  logic                   wvalid;
  logic                   wready;
  logic [1:0]             bresp;
  logic                   bvalid;
  logic                   bready;
  logic [AddrWidth-1:0]   araddr;
  logic [2:0]             arprot;
  logic                   arvalid;
  logic                   arready;
  logic [DataWidth-1:0]   rdata;
  logic [1:0]             rresp;
  logic                   rvalid;
  logic                   rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4_lite_intl_regbank.sv
// AXI4-Lite interlock register bank: N setpoint/status words, CTRL word at index N.
// Optional macro INTL_SHADOW_EN adds shadow words with an atomic CTRL-triggered commit.
module axi4_lite_intl_regbank #(
  parameter int unsigned                 C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned                 C_S_AXI_ADDR_NUM   = 32,
  parameter int unsigned                 C_S_AXI_ADDR_WIDTH = 8,
  parameter logic [C_S_AXI_ADDR_NUM-1:0] C_IO_SEL           = '1
) (
  input  logic                           S_AXI_ACLK,
  input  logic                           S_AXI_ARESET,
  axi4_lite_intl_regbank_if.slave        s_axi,
  input  logic [C_S_AXI_ADDR_NUM*32-1:0] i_status,
  output logic [C_S_AXI_ADDR_NUM*32-1:0] o_reg,
  output logic [C_S_AXI_ADDR_NUM-1:0]    o_wr_strb,
  output logic                           o_commit
);
  localparam int unsigned N          = C_S_AXI_ADDR_NUM;
  localparam int unsigned DW         = C_S_AXI_DATA_WIDTH;
  localparam int unsigned AddrLsb    = 2;
  localparam int unsigned IdxBits    = C_S_AXI_ADDR_WIDTH - AddrLsb;
  localparam logic [1:0]  RespOkay   = 2'b00;
  localparam logic [1:0]  RespSlvErr = 2'b10;

  logic               aw_hold_q, w_hold_q, bvalid_q, rvalid_q;
  logic [IdxBits-1:0] widx_q;
  logic [DW-1:0]      wdata_q, rdata_q;
  logic [DW/8-1:0]    wstrb_q;
  logic [1:0]         bresp_q, rresp_q;
  logic [N-1:0]       wr_strb_q;
  logic [DW-1:0]      store_q [N];

  logic               aw_hs, w_hs, ar_hs, exec;
  logic               wr_data, wr_ctrl, rd_err;
  logic [DW-1:0]      merged, rd_val, ctrl_rd;
  logic [IdxBits-1:0] ridx;
  logic               unused_bits;

  assign s_axi.awready = ~aw_hold_q;
  assign s_axi.wready  = ~w_hold_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = ~rvalid_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;
  assign o_wr_strb     = wr_strb_q;

  assign aw_hs   = s_axi.awvalid & ~aw_hold_q;
  assign w_hs    = s_axi.wvalid & ~w_hold_q;
  assign ar_hs   = s_axi.arvalid & ~rvalid_q;
  assign exec    = aw_hold_q & w_hold_q & ~bvalid_q;
  assign wr_ctrl = (widx_q == IdxBits'(N));
  assign ridx    = s_axi.araddr[AddrLsb +: IdxBits];

  assign unused_bits = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[AddrLsb-1:0],
                         s_axi.araddr[AddrLsb-1:0]};

  // Byte-merge the latched write into the addressed output word.
  always_comb begin
    wr_data = 1'b0;
    merged  = '0;
    for (int i = 0; i < N; i++) begin
      if (widx_q == IdxBits'(i) && C_IO_SEL[i]) begin
        wr_data = 1'b1;
        for (int b = 0; b < DW / 8; b++) begin
          merged[8*b +: 8] = wstrb_q[b] ? wdata_q[8*b +: 8] : store_q[i][8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    rd_val = '0;
    rd_err = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (ridx == IdxBits'(i)) begin
        rd_err = 1'b0;
        rd_val = C_IO_SEL[i] ? store_q[i] : i_status[i*32 +: 32];
      end
    end
    if (ridx == IdxBits'(N)) begin
      rd_err = 1'b0;
      rd_val = ctrl_rd;
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      aw_hold_q <= 1'b0;
      w_hold_q  <= 1'b0;
      widx_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RespOkay;
      wr_strb_q <= '0;
      for (int i = 0; i < N; i++) store_q[i] <= '0;
    end else begin
      wr_strb_q <= '0;
      if (aw_hs) begin
        aw_hold_q <= 1'b1;
        widx_q    <= s_axi.awaddr[AddrLsb +: IdxBits];
      end
      if (w_hs) begin
        w_hold_q <= 1'b1;
        wdata_q  <= s_axi.wdata;
        wstrb_q  <= s_axi.wstrb;
      end
      if (bvalid_q & s_axi.bready) bvalid_q <= 1'b0;
      if (exec) begin
        aw_hold_q <= 1'b0;
        w_hold_q  <= 1'b0;
        bvalid_q  <= 1'b1;
        bresp_q   <= (wr_data | wr_ctrl) ? RespOkay : RespSlvErr;
        for (int i = 0; i < N; i++) begin
          if (wr_data && widx_q == IdxBits'(i)) begin
            store_q[i]   <= merged;
            wr_strb_q[i] <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RespOkay;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_err ? '0 : rd_val;
      rresp_q  <= rd_err ? RespSlvErr : RespOkay;
    end else if (rvalid_q & s_axi.rready) begin
      rvalid_q <= 1'b0;
    end
  end

`ifdef INTL_SHADOW_EN
  logic          pending_q, commit_q, do_commit;
  logic [DW-1:0] live_q [N];

  // Commit needs bit0 actually written, i.e. byte lane 0 enabled.
  assign do_commit = exec & wr_ctrl & wstrb_q[0] & wdata_q[0];
  assign ctrl_rd   = {{(DW-1){1'b0}}, pending_q};
  assign o_commit  = commit_q;

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      pending_q <= 1'b0;
      commit_q  <= 1'b0;
      for (int i = 0; i < N; i++) live_q[i] <= '0;
    end else begin
      commit_q <= do_commit;
      if (do_commit) begin
        pending_q <= 1'b0;
        for (int i = 0; i < N; i++) live_q[i] <= store_q[i];
      end else if (exec & wr_data) begin
        pending_q <= 1'b1;
      end
    end
  end

  always_comb begin
    o_reg = '0;
    for (int i = 0; i < N; i++) if (C_IO_SEL[i]) o_reg[i*32 +: 32] = live_q[i];
  end
`else
  assign ctrl_rd  = '0;
  assign o_commit = 1'b0;

  always_comb begin
    o_reg = '0;
    for (int i = 0; i < N; i++) if (C_IO_SEL[i]) o_reg[i*32 +: 32] = store_q[i];
  end
`endif
endmodule

// File: tb/tb_axi4_lite_intl_regbank.sv
// Randomized self-checking bench for axi4_lite_intl_regbank against a transaction-level model.
module tb_axi4_lite_intl_regbank;
  localparam int unsigned N     = 32;
  localparam int unsigned AW    = 8;
  localparam logic [N-1:0] IoSel = 32'hFFEF_FF7F;
`ifdef INTL_SHADOW_EN
  localparam bit ShadowEn = 1'b1;
`else
  localparam bit ShadowEn = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N*32-1:0] i_status;
  logic [N*32-1:0] o_reg;
  logic [N-1:0]    o_wr_strb;
  logic            o_commit;

  int checks = 0, errors = 0;
  int strb_cnt = 0, strb_wsum = 0, commit_cnt = 0;
  int exp_strb_cnt = 0, exp_strb_wsum = 0, exp_commit_cnt = 0;
  logic [31:0] shadow_m [N];
  logic [31:0] live_m [N];
  bit          pending_m;

  always #5 clk = ~clk;

  axi4_lite_intl_regbank_if #(.AddrWidth(AW), .DataWidth(32)) bus ();

  axi4_lite_intl_regbank #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_NUM  (N),
    .C_S_AXI_ADDR_WIDTH(AW),
    .C_IO_SEL          (IoSel)
  ) dut (
    .S_AXI_ACLK  (clk),
    .S_AXI_ARESET(rst),
    .s_axi       (bus),
    .i_status    (i_status),
    .o_reg       (o_reg),
    .o_wr_strb   (o_wr_strb),
    .o_commit    (o_commit)
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (o_commit) commit_cnt++;
      for (int i = 0; i < N; i++) begin
        if (o_wr_strb[i]) begin
          strb_cnt++;
          strb_wsum += i + 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] oword(input int i);
    return o_reg[i*32 +: 32];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      shadow_m[i] = '0;
      live_m[i]   = '0;
    end
    pending_m = 1'b0;
  endtask

  task automatic model_write(input int idx, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp, output logic [31:0] estrb,
                             output logic ecommit);
    logic [31:0] mask;
    mask    = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    resp    = 2'b10;
    estrb   = '0;
    ecommit = 1'b0;
    if (idx < N && IoSel[idx]) begin
      resp          = 2'b00;
      estrb         = 32'd1 << idx;
      shadow_m[idx] = (shadow_m[idx] & ~mask) | (data & mask);
      if (ShadowEn) pending_m = 1'b1;
      else live_m[idx] = shadow_m[idx];
    end else if (idx == N) begin
      resp = 2'b00;
      if (ShadowEn && strb[0] && data[0]) begin
        ecommit   = 1'b1;
        pending_m = 1'b0;
        for (int i = 0; i < N; i++) live_m[i] = shadow_m[i];
      end
    end
    if (estrb != 0) begin
      exp_strb_cnt++;
      exp_strb_wsum += idx + 1;
    end
    if (ecommit) exp_commit_cnt++;
  endtask

  task automatic model_read(input int idx, output logic [31:0] data, output logic [1:0] resp);
    resp = 2'b00;
    if (idx < N) data = IoSel[idx] ? shadow_m[idx] : i_status[idx*32 +: 32];
    else if (idx == N) data = ShadowEn ? {31'b0, pending_m} : 32'd0;
    else begin
      data = '0;
      resp = 2'b10;
    end
  endtask

  // w_lead > 0: W presented that many cycles before AW; < 0: AW leads.
  task automatic axi_write(input int idx, input logic [31:0] data, input logic [3:0] strb,
                           input int w_lead, input bit keep_b);
    logic [1:0]  eresp;
    logic [31:0] estrb;
    logic        ecommit;
    bit          aw_done, w_done, aw_now, w_now;
    int          cyc, lat;
    model_write(idx, data, strb, eresp, estrb, ecommit);
    @(negedge clk);
    bus.awaddr  = AW'(idx * 4);
    bus.wdata   = data;
    bus.wstrb   = strb;
    bus.awvalid = (w_lead <= 0);
    bus.wvalid  = (w_lead >= 0);
    aw_done = 1'b0;
    w_done  = 1'b0;
    cyc     = 0;
    while (!(aw_done && w_done) && cyc < 40) begin
      aw_now = bus.awvalid && bus.awready;
      w_now  = bus.wvalid && bus.wready;
      @(negedge clk);
      cyc++;
      if (aw_now) begin aw_done = 1'b1; bus.awvalid = 1'b0; end
      if (w_now)  begin w_done  = 1'b1; bus.wvalid  = 1'b0; end
      if (!aw_done && cyc >= w_lead)  bus.awvalid = 1'b1;
      if (!w_done  && cyc >= -w_lead) bus.wvalid  = 1'b1;
    end
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    chk("w_accept", {30'b0, aw_done, w_done}, 32'd3);
    lat = 0;
    while (!bus.bvalid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("b_latency", lat, 1);
    chk("bresp", 32'(bus.bresp), 32'(eresp));
    chk("wr_strb", o_wr_strb, estrb);
    chk("commit", 32'(o_commit), 32'(ecommit));
    if (ecommit) begin
      for (int i = 0; i < N; i++) chk("commit_oreg", oword(i), live_m[i]);
    end else if (idx < N) begin
      chk("oreg_word", oword(idx), live_m[idx]);
    end
    if (!keep_b) begin
      bus.bready = 1'b1;
      @(negedge clk);
      bus.bready = 1'b0;
    end
  endtask

  task automatic axi_read(input int idx);
    logic [31:0] ed;
    logic [1:0]  er;
    int          cyc, d;
    model_read(idx, ed, er);
    @(negedge clk);
    bus.araddr  = AW'(idx * 4);
    bus.arvalid = 1'b1;
    cyc = 0;
    while (!bus.arready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("ar_ready", 32'(bus.arready), 1);
    @(negedge clk);
    bus.arvalid = 1'b0;
    chk("rvalid", 32'(bus.rvalid), 1);
    chk("rdata", bus.rdata, ed);
    chk("rresp", 32'(bus.rresp), 32'(er));
    d = int'($urandom_range(0, 2));
    repeat (d) @(negedge clk);
    chk("rdata_hold", bus.rdata, ed);
    bus.rready = 1'b1;
    @(negedge clk);
    bus.rready = 1'b0;
  endtask

  initial begin
    logic [1:0]  er;
    logic [31:0] estrb, old10;
    logic        ec;
    int          op, idx;

    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata  = '0; bus.wstrb  = '0; bus.wvalid  = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    for (int i = 0; i < N; i++) i_status[i*32 +: 32] = $urandom();
    model_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_awready", 32'(bus.awready), 1);
    chk("rst_wready", 32'(bus.wready), 1);
    chk("rst_arready", 32'(bus.arready), 1);
    chk("rst_bvalid", 32'(bus.bvalid), 0);
    chk("rst_rvalid", 32'(bus.rvalid), 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_oreg", 32'(|o_reg), 0);
    chk("rst_strb", o_wr_strb, 0);
    chk("rst_commit", 32'(o_commit), 0);

    axi_write(3, 32'h0000_1234, 4'hF, 0, 1'b0);
    axi_read(N);
    axi_write(N, 32'h1, 4'hF, 0, 1'b0);
    axi_read(N);
    axi_read(3);
    axi_write(5, 32'hFFFF_FFFF, 4'b0101, 3, 1'b0);
    axi_read(5);
    i_status[7*32 +: 32] = 32'hA5A5_0001;
    axi_read(7);
    axi_write(7, 32'hDEAD_BEEF, 4'hF, 0, 1'b0);
    axi_read(40);
    axi_write(40, 32'h1357_9BDF, 4'hF, -2, 1'b0);
    axi_read(N);
    axi_write(0, 32'h55, 4'hF, 0, 1'b0);
    axi_write(6, 32'hCAFE_F00D, 4'h0, 1, 1'b0);

    // Back-pressured B: a second write may latch but must not execute.
    axi_write(9, 32'h0909_0909, 4'hF, 0, 1'b1);
    old10 = live_m[10];
    @(negedge clk);
    bus.awaddr = AW'(10 * 4); bus.wdata = 32'h1010_1010; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    chk("hold_awready", 32'(bus.awready), 0);
    chk("hold_wready", 32'(bus.wready), 0);
    repeat (8) @(negedge clk);
    chk("hold_bvalid", 32'(bus.bvalid), 1);
    chk("hold_strb", o_wr_strb, 0);
    chk("hold_oreg10", oword(10), old10);
    model_write(10, 32'h1010_1010, 4'hF, er, estrb, ec);
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    chk("hold_bdrop", 32'(bus.bvalid), 0);
    @(negedge clk);
    chk("hold2_bvalid", 32'(bus.bvalid), 1);
    chk("hold2_bresp", 32'(bus.bresp), 32'(er));
    chk("hold2_strb", o_wr_strb, estrb);
    chk("hold2_oreg10", oword(10), live_m[10]);
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;

    for (int n = 0; n < 80; n++) begin
      op = int'($urandom_range(0, 4));
      if (op <= 1) begin
        axi_write(int'($urandom_range(0, 40)), $urandom(), 4'($urandom()),
                  int'($urandom_range(0, 6)) - 3, 1'b0);
      end else if (op <= 3) begin
        i_status[7*32 +: 32]  = $urandom();
        i_status[20*32 +: 32] = $urandom();
        idx = int'($urandom_range(0, 40));
        axi_read(idx);
      end else begin
        axi_write(N, $urandom(), 4'hF, int'($urandom_range(0, 4)) - 2, 1'b0);
      end
    end
    axi_write(N, 32'h1, 4'hF, 0, 1'b0);
    axi_read(3);
    axi_read(20);

    // Reset with an AW latched but no W: the transaction must vanish.
    @(negedge clk);
    bus.awaddr = AW'(3 * 4); bus.awvalid = 1'b1;
    @(negedge clk);
    bus.awvalid = 1'b0;
    chk("mid_awready", 32'(bus.awready), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("mid_awready_rst", 32'(bus.awready), 1);
    chk("mid_oreg", 32'(|o_reg), 0);
    bus.wdata = 32'hFFFF_FFFF; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(negedge clk);
    bus.wvalid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_no_bvalid", 32'(bus.bvalid), 0);
    axi_read(3);

    chk("strb_pulses", strb_cnt, exp_strb_cnt);
    chk("strb_wsum", strb_wsum, exp_strb_wsum);
    chk("commit_pulses", commit_cnt, exp_commit_cnt);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi4_lite_intl_regbank.md
# axi4_lite_intl_regbank

Parametrised AXI4-Lite register bank for the interlock subsystem, successor to the fixed 19-setpoint interlock register block. It holds N threshold/setpoint words. A per-register direction mask makes each word either a PS-writable output or a PL-driven read-only status input. It adds independent AW/W acceptance, SLVERR responses, per-register write strobes and an optional shadow/commit stage so that setpoint groups update atomically. It sits between the PS AXI GP port (through the interconnect) and the interlock comparators.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
- C_S_AXI_ADDR_NUM, 32, number of data registers N (2..256).
- C_S_AXI_ADDR_WIDTH, 8, byte-address width; must cover (N+1)*4 bytes.
- C_IO_SEL, all ones, N-bit mask; bit i: 1 = output register (R/W), 0 = input register (read-only, sourced from i_status).
- S_AXI_ACLK  in  1  single clock for all logic.
- S_AXI_ARESET  in  1  synchronous, active-high reset.
- S_AXI_AW*/W*/B*/AR*/R*  standard AXI4-Lite slave channels, widths per parameters; AWPROT/ARPROT ignored.
- i_status  in  N*32  flat input words; word i at [32i+31:32i]; used where C_IO_SEL[i]=0.
- o_reg  out  N*32  flat live output words; word i is held 0 where C_IO_SEL[i]=0.
- o_wr_strb  out  N  one-cycle pulse per register on an accepted write to it.
- o_commit  out  1  one-cycle pulse when live outputs load from shadow.

## Operation
- Register map: word index k = addr[ADDR_LSB+:idx_bits] with ADDR_LSB=2. Index 0..N-1 are data registers. Index N is CTRL. Indices >N are out of range.
- Each output register has a shadow word. AXI writes go to the shadow. Reads of an output register return the shadow. Reads of an input register return i_status[i], sampled in the AR handshake cycle.
- Writes apply WSTRB per byte. A write to an input register or an out-of-range index leaves all state unchanged and responds BRESP=2'b10 (SLVERR). All other writes respond 2'b00.
- Reads of an out-of-range index return RDATA=0 with RRESP=2'b10. All other reads return RRESP=2'b00.
- CTRL: writing bit0=1 requests a commit. CTRL reads return {31'b0, pending}. pending sets on any accepted data-register write and clears on commit.
- A commit copies every shadow into o_reg simultaneously and pulses o_commit.
- A commit with pending=0 still copies and pulses; it is harmless.
- o_wr_strb[i] pulses on every accepted write to register i, including writes with WSTRB=0.

## Timing
- Reset: every shadow, o_reg, o_wr_strb, o_commit, pending, BVALID, RVALID, RDATA and both hold flags go to 0. AWREADY and WREADY go high and ARREADY goes high in the cycle after reset deasserts. A reset asserted mid-transaction drops that transaction without issuing a response.
- AW and W are accepted independently and in any order. AWREADY = ~aw_hold and WREADY = ~w_hold, both combinational from registered flags. A channel handshake sets its hold flag and latches its payload.
- Write execute cycle E is the first cycle with aw_hold & w_hold & ~BVALID. In E, the shadow/CTRL update is registered at the clock edge, both holds clear, BVALID rises on the next edge, and o_wr_strb pulses in cycle E+1.
- Best case: AW and W in cycle 0, E = cycle 1, BVALID in cycle 2.
- BVALID holds until BREADY. At most one write is outstanding.
- Read: ARREADY = ~RVALID. RDATA and RVALID are registered on the edge after the AR handshake. RVALID holds with RDATA stable until RREADY. Reads and writes proceed concurrently.
- A read of a register written in the same edge returns the pre-write value.
- The o_reg update and o_commit pulse occur in cycle E+1 of the CTRL write.

## Configuration
- INTL_SHADOW_EN defined: shadow/commit behaviour as described above.
- INTL_SHADOW_EN undefined: no shadow storage. Each write updates o_reg directly in cycle E+1, together with o_wr_strb. CTRL writes respond OKAY with no effect. CTRL reads return 0. o_commit is tied 0.

## Test plan
- Reset, then N=32 with INTL_SHADOW_EN: write 0x0000_1234 to idx 3 -> BRESP OKAY, o_wr_strb[3] pulses, o_reg word3 stays 0, CTRL read = 1. Then write CTRL=1 -> o_reg word3 = 0x1234, o_commit pulses once, CTRL read = 0.
- W issued 3 cycles before AW for idx 5, data 0xFFFF_FFFF, WSTRB=4'b0101 -> shadow5 = 0x00FF_00FF, BVALID 2 cycles after the AW handshake.
- C_IO_SEL bit 7 = 0, i_status word7 = 0xA5A5_0001: read idx7 -> RDATA 0xA5A5_0001 OKAY. Write idx7 -> SLVERR, no o_wr_strb pulse.
- Read idx 40 (out of range) -> RDATA 0, RRESP SLVERR. Write idx 40 -> SLVERR, pending unchanged.
- Hold BREADY low 10 cycles after a write -> BVALID stays high, AWREADY/WREADY fall once a second AW and W are latched, and the second write executes only after BREADY.
- Macro undefined: write 0x55 to idx0 -> o_reg word0 = 0x55 in E+1, o_commit never asserts.
